// File: rtl/spram_dma_wr_pkg.sv
// spram_dma_wr_pkg
//   Shared types and helpers for the SPRAM DMA write front end.
//   - state_t        : control FSM encoding (IDLE / RUN / DONE)
//   - bytes_per_word : stream bytes packed into one RAM word
//   - bcnt_width     : width of the byte-in-word counter
package spram_dma_wr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

   // Keep at least one bit so a single-byte word still has a legal counter.
   function automatic int bcnt_width(input int data_width);
      return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
   endfunction

endpackage

// File: rtl/spram_dma_wr_if.sv
// spram_dma_wr_if
//   Bundles the CPU port, DMA control, byte stream and RAM port of
//   spram_dma_wr.
//   slave  : the DMA block side (consumes CPU/DMA/stream, drives RAM)
//   master : the environment side (CPU, DMA controller, stream source, RAM)
interface spram_dma_wr_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
);
   // CPU port
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_din;
   logic                  cpu_we;
   logic                  cpu_re;
   logic                  cpu_hold;
   // DMA control
   logic                  dma_start;
   logic [ADDR_WIDTH-1:0] dma_addr;
   logic [ADDR_WIDTH-1:0] dma_len;
   logic                  busy;
   logic                  done;
   // byte stream
   logic [7:0]            s_data;
   logic                  s_valid;
   logic                  s_ready;
   // RAM port
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_din;
   logic                  ram_we;
   logic                  ram_re;

   modport slave (
      input  cpu_addr, cpu_din, cpu_we, cpu_re,
      input  dma_start, dma_addr, dma_len,
      input  s_data, s_valid,
      output cpu_hold, busy, done, s_ready,
      output ram_addr, ram_din, ram_we, ram_re
   );

   modport master (
      output cpu_addr, cpu_din, cpu_we, cpu_re,
      output dma_start, dma_addr, dma_len,
      output s_data, s_valid,
      input  cpu_hold, busy, done, s_ready,
      input  ram_addr, ram_din, ram_we, ram_re
   );
endinterface

// File: rtl/spram_dma_wr_fifo.sv
// spram_dma_wr_fifo
//   Synchronous first-word-fall-through FIFO.
//   Ports: clk, rst (async high), push/wdata, pop, full, empty,
//          head (current oldest entry, valid while !empty).
//   Pointers carry one extra wrap bit so full and empty are distinct.
module spram_dma_wr_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wp, rp;
   logic             do_push, do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
      end
   end

   // Storage needs no reset: entries are only read while the pointers say valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= wdata;
   end

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign head  = mem[rp[AW-1:0]];

endmodule

// File: rtl/spram_dma_wr.sv
// spram_dma_wr
//   Write-side DMA front end for a single-port RAM. Packs a little-endian
//   byte stream into DATA_WIDTH words, buffers them in a small FIFO and
//   writes them to consecutive RAM addresses in cycles the CPU leaves idle.
//   Ports: clk, rst (async high) and one spram_dma_wr_if.slave bundle:
//     cpu_*    : CPU request in, cpu_hold out when the DMA takes the port
//     dma_*    : start pulse, first address, word count; busy/done status
//     s_*      : byte stream (valid/ready)
//     ram_*    : RAM addr/din/we/re
module spram_dma_wr
   import spram_dma_wr_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   spram_dma_wr_if.slave   bus
);
   localparam int BPW = bytes_per_word(DATA_WIDTH);
   localparam int BW  = bcnt_width(DATA_WIDTH);
   localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] ptr, pack_left, write_left;
   logic [BW-1:0]         byte_cnt;
   logic [DATA_WIDTH-1:0] part, word_nx, head;
   logic                  zero_done;
   logic                  run, start_ok, creq, dma_slot, acc, push;
   logic                  full, empty, s_ready_i;

   assign run       = (state == RUN);
   assign start_ok  = (state == IDLE) & bus.dma_start;
   assign creq      = bus.cpu_we | bus.cpu_re;
   // CPU normally wins; a full FIFO steals the port so the stream keeps
   // moving and a held CPU waits at most FIFO_DEPTH cycles.
   assign dma_slot  = run & ~empty & (~creq | full);
   assign s_ready_i = run & (pack_left != '0) & ~full;
   assign acc       = bus.s_valid & s_ready_i;
   assign push      = acc & (byte_cnt == LAST_BYTE);

   // Partial word with the incoming byte merged in at its lane.
   always_comb begin
      word_nx = part;
      word_nx[{byte_cnt, 3'b000} +: 8] = bus.s_data;
   end

   spram_dma_wr_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (word_nx),
      .pop   (dma_slot),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   // ---- FSM: state register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start_ok && bus.dma_len != '0) state_nx = RUN;
         // Leave on the edge that retires the last word.
         RUN:  if (write_left == '0 ||
                   (dma_slot && write_left == ADDR_WIDTH'(1))) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   // A zero-length start stays in IDLE and reports completion via zero_done.
   always_comb begin
      bus.busy = (state == RUN);
      bus.done = (state == DONE) | zero_done;
   end

   // ---- datapath counters and packer ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr        <= '0;
         pack_left  <= '0;
         write_left <= '0;
         byte_cnt   <= '0;
         part       <= '0;
         zero_done  <= 1'b0;
      end else begin
         zero_done <= start_ok & (bus.dma_len == '0);
         if (start_ok) begin
            ptr        <= bus.dma_addr;
            pack_left  <= bus.dma_len;
            write_left <= bus.dma_len;
            byte_cnt   <= '0;
         end else begin
            if (acc) begin
               if (push) begin
                  byte_cnt  <= '0;
                  pack_left <= pack_left - 1'b1;
               end else begin
                  byte_cnt <= byte_cnt + 1'b1;
                  part     <= word_nx;
               end
            end
            if (dma_slot) begin
               ptr        <= ptr + 1'b1;
               write_left <= write_left - 1'b1;
            end
         end
      end
   end

   // ---- RAM port arbitration ----
   always_comb begin
      bus.ram_addr = bus.cpu_addr;
      bus.ram_din  = bus.cpu_din;
      bus.ram_we   = bus.cpu_we;
      bus.ram_re   = bus.cpu_re;
      bus.cpu_hold = 1'b0;
      if (dma_slot) begin
         bus.ram_addr = ptr;
         bus.ram_din  = head;
         bus.ram_we   = 1'b1;
         bus.ram_re   = 1'b0;
         bus.cpu_hold = creq;
      end
   end

   assign bus.s_ready = s_ready_i;

endmodule

// File: tb/tb_spram_dma_wr.sv
// tb_spram_dma_wr
//   Directed bench for spram_dma_wr: a per-cycle vector table for a plain
//   transfer, then hand-written sequences for zero length, address wrap,
//   CPU contention, CPU-wins arbitration and reset mid-transfer.
//   Inputs change on the falling edge; outputs are sampled 2 time units later.
module tb_spram_dma_wr;
   localparam int AW = 10;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spram_dma_wr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   spram_dma_wr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // RAM model: records every write the DUT issues.
   logic [DW-1:0] mem [1024];
   int we_cnt = 0;
   always @(negedge clk) begin
      #2;
      if (bus.ram_we === 1'b1) begin
         mem[bus.ram_addr] = bus.ram_din;
         we_cnt++;
      end
   end

   // ---- vector table ----
   // exp = {ram_we, ram_re, ram_addr, ram_din, cpu_hold, s_ready, busy, done}
   typedef struct {
      logic          start;
      logic          sv;
      logic [7:0]    sd;
      logic          cwe;
      logic          cre;
      logic [AW-1:0] caddr;
      logic [DW-1:0] cdin;
      logic [31:0]   expv;
   } vec_t;

   function automatic vec_t row(input logic start, input logic sv, input logic [7:0] sd,
                                input logic cwe, input logic cre, input logic [AW-1:0] ca,
                                input logic [DW-1:0] cd, input logic we, input logic re,
                                input logic [AW-1:0] ra, input logic [DW-1:0] rd,
                                input logic hold, input logic srdy, input logic bsy,
                                input logic dn);
      vec_t v;
      v.start = start; v.sv = sv; v.sd = sd; v.cwe = cwe; v.cre = cre;
      v.caddr = ca; v.cdin = cd;
      v.expv  = {we, re, ra, rd, hold, srdy, bsy, dn};
      return v;
   endfunction

   function automatic logic [31:0] outs();
      return {bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_din,
              bus.cpu_hold, bus.s_ready, bus.busy, bus.done};
   endfunction

   // ---- streaming helper ----
   logic [7:0] bq [$];

   task automatic run_xfer(input logic [AW-1:0] a, input logic [AW-1:0] n, input bit hold);
      int idx, hrun, maxrun, holds;
      bit got_done;
      idx = 0; hrun = 0; maxrun = 0; holds = 0; got_done = 0;
      bus.dma_addr = a; bus.dma_len = n; bus.dma_start = 1'b1;
      @(negedge clk);
      bus.dma_start = 1'b0;
      for (int c = 0; c < 300 && !got_done; c++) begin
         bus.s_valid  = (idx < bq.size());
         bus.s_data   = (idx < bq.size()) ? bq[idx] : 8'h00;
         bus.cpu_re   = hold && (idx < bq.size());
         bus.cpu_addr = 10'h055;
         #2;
         if (bus.cpu_re) begin
            if (bus.cpu_hold) begin
               holds++; hrun++;
               chk("held_no_re", bus.ram_re, 1'b0);
               chk("held_dma_we", bus.ram_we, 1'b1);
            end else begin
               hrun = 0;
               chk("cpu_re_pass", {bus.ram_re, bus.ram_we, bus.ram_addr}, {2'b10, 10'h055});
            end
            if (hrun > maxrun) maxrun = hrun;
         end
         if (bus.s_valid && bus.s_ready) idx++;
         if (bus.done) got_done = 1;
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      bus.cpu_re  = 1'b0;
      chk("xfer_done", got_done, 1'b1);
      chk("all_bytes", idx, bq.size());
      if (hold) begin
         chk("fifo_full_hold_seen", holds > 0, 1'b1);
         chk("hold_bound", maxrun <= 4, 1'b1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl [12];
      int   w0;

      foreach (mem[i]) mem[i] = '0;
      rst = 1'b1;
      bus.cpu_addr = 10'h03A; bus.cpu_din = '0; bus.cpu_we = 1'b0; bus.cpu_re = 1'b1;
      bus.dma_start = 1'b0; bus.dma_addr = '0; bus.dma_len = '0;
      bus.s_data = '0; bus.s_valid = 1'b0;

      // reset: CPU passthrough, everything else quiet
      @(negedge clk); #2;
      chk("rst_outs", outs(), {1'b0, 1'b1, 10'h03A, 16'h0000, 4'b0000});
      @(negedge clk);
      bus.cpu_re = 1'b0; bus.cpu_addr = '0;
      rst = 1'b0;
      @(negedge clk);

      // 1: addr 0x010, len 3, bytes 11..66, no CPU traffic
      tbl[0]  = row(1, 0, 8'h00, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0, 0, 0);
      tbl[1]  = row(0, 1, 8'h11, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 1, 1, 0);
      tbl[2]  = row(0, 1, 8'h22, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 1, 1, 0);
      tbl[3]  = row(0, 1, 8'h33, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h010, 16'h2211, 0, 1, 1, 0);
      tbl[4]  = row(0, 1, 8'h44, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 1, 1, 0);
      tbl[5]  = row(0, 1, 8'h55, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h011, 16'h4433, 0, 1, 1, 0);
      tbl[6]  = row(0, 1, 8'h66, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 1, 1, 0);
      tbl[7]  = row(0, 0, 8'h00, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h012, 16'h6655, 0, 0, 1, 0);
      tbl[8]  = row(0, 0, 8'h00, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0, 0, 1);
      tbl[9]  = row(0, 0, 8'h00, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0, 0, 0);
      tbl[10] = row(0, 0, 8'h00, 0, 1, 10'h0AB, 16'h0000, 0, 1, 10'h0AB, 16'h0000, 0, 0, 0, 0);
      tbl[11] = row(0, 0, 8'h00, 1, 0, 10'h077, 16'h1234, 1, 0, 10'h077, 16'h1234, 0, 0, 0, 0);
      bus.dma_addr = 10'h010; bus.dma_len = 10'd3;
      for (int i = 0; i < 12; i++) begin
         bus.dma_start = tbl[i].start; bus.s_valid = tbl[i].sv; bus.s_data = tbl[i].sd;
         bus.cpu_we = tbl[i].cwe; bus.cpu_re = tbl[i].cre;
         bus.cpu_addr = tbl[i].caddr; bus.cpu_din = tbl[i].cdin;
         #2;
         chk($sformatf("vec%0d", i), outs(), tbl[i].expv);
         @(negedge clk);
      end
      bus.cpu_we = 1'b0; bus.cpu_re = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
      chk("t1_mem010", mem[10'h010], 16'h2211);
      chk("t1_mem011", mem[10'h011], 16'h4433);
      chk("t1_mem012", mem[10'h012], 16'h6655);

      // 2: zero length -> done one cycle later, no writes, no s_ready
      w0 = we_cnt;
      bus.dma_addr = 10'h040; bus.dma_len = 10'd0; bus.dma_start = 1'b1; bus.s_valid = 1'b1;
      #2;
      chk("t2_c0_done", bus.done, 1'b0);
      @(negedge clk);
      bus.dma_start = 1'b0;
      #2;
      chk("t2_c1", {bus.done, bus.busy, bus.s_ready}, 3'b100);
      @(negedge clk); #2;
      chk("t2_c2", {bus.done, bus.busy, bus.s_ready}, 3'b000);
      @(negedge clk);
      bus.s_valid = 1'b0;
      chk("t2_no_we", we_cnt, w0);

      // 3: address wrap 0x3FF -> 0x000
      bq = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_xfer(10'h3FF, 10'd2, 1'b0);
      chk("t3_mem3ff", mem[10'h3FF], 16'h0201);
      chk("t3_mem000", mem[10'h000], 16'h0403);

      // 4: CPU reads continuously while 16 bytes stream in
      bq = {};
      for (int i = 0; i < 16; i++) bq.push_back(8'h80 + 8'(i));
      run_xfer(10'h100, 10'd8, 1'b1);
      for (int k = 0; k < 8; k++)
         chk($sformatf("t4_mem%0d", k), mem[10'h100 + 10'(k)],
             {8'h80 + 8'(2*k+1), 8'h80 + 8'(2*k)});

      // 5: CPU write wins over a non-full FIFO; DMA write follows
      bus.dma_addr = 10'h030; bus.dma_len = 10'd1; bus.dma_start = 1'b1;
      @(negedge clk);
      bus.dma_start = 1'b0; bus.s_valid = 1'b1; bus.s_data = 8'hCD;
      @(negedge clk);
      bus.s_data = 8'hAB;
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.cpu_we = 1'b1; bus.cpu_addr = 10'h020; bus.cpu_din = 16'hBEEF;
      #2;
      chk("t5_cpu_wins", {bus.ram_we, bus.cpu_hold, bus.ram_addr, bus.ram_din},
          {2'b10, 10'h020, 16'hBEEF});
      @(negedge clk);
      bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
      #2;
      chk("t5_dma_next", {bus.ram_we, bus.ram_addr, bus.ram_din}, {1'b1, 10'h030, 16'hABCD});
      @(negedge clk); #2;
      chk("t5_done", bus.done, 1'b1);
      @(negedge clk);
      chk("t5_mem020", mem[10'h020], 16'hBEEF);
      chk("t5_mem030", mem[10'h030], 16'hABCD);

      // 6: reset after 3 of 6 bytes
      bus.dma_addr = 10'h200; bus.dma_len = 10'd3; bus.dma_start = 1'b1;
      @(negedge clk);
      bus.dma_start = 1'b0; bus.s_valid = 1'b1;
      bus.s_data = 8'h11; @(negedge clk);
      bus.s_data = 8'h22; @(negedge clk);
      bus.s_data = 8'h33; @(negedge clk);
      bus.s_data = 8'h44;
      rst = 1'b1;
      #2;
      chk("t6_rst_now", {bus.busy, bus.s_ready, bus.ram_we}, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      w0 = we_cnt;
      for (int c = 0; c < 4; c++) begin
         #2;
         chk("t6_quiet", {bus.busy, bus.s_ready, bus.ram_we}, 3'b000);
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      chk("t6_no_we", we_cnt, w0);
      chk("t6_mem200", mem[10'h200], 16'h2211);
      chk("t6_mem201", mem[10'h201], 16'h0000);
      bq = '{8'h77, 8'h88};
      run_xfer(10'h210, 10'd1, 1'b0);
      chk("t6_mem210", mem[10'h210], 16'h8877);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
